// File: rtl/spi_ip_pkg.sv
// Shared types and constants for the SB_SPI config sequencer.
// State encoding, end marker and SB_SPI register map.
package spi_ip_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_WRITE  = 3'd3,
      ST_READ   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [7:0] END_MARKER = 8'hFF;

   localparam logic [7:0] SPIIRQEN = 8'h07;
   localparam logic [7:0] SPICR0   = 8'h08;
   localparam logic [7:0] SPICR1   = 8'h09;
   localparam logic [7:0] SPICR2   = 8'h0A;
   localparam logic [7:0] SPIBR    = 8'h0B;
   localparam logic [7:0] SPICSR   = 8'h0F;

endpackage

// File: rtl/sb_bus_master.sv
// SB_SPI system-bus strobe/ack handshake with ack timeout.
// req/we/adr/dat in; ack_done/timeout/rdata out; sb_* bus pins.
// SPI_CFG_VERIFY_EN: rdata carries sb_dat_r for read-back.
module sb_bus_master #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       we,
   input  logic [7:0] adr,
   input  logic [7:0] dat,
   output logic       ack_done,
   output logic       timeout,
   output logic [7:0] rdata,
   output logic [7:0] sb_adr,
   output logic [7:0] sb_dat_w,
   output logic       sb_we,
   output logic       sb_stb,
   input  logic [7:0] sb_dat_r,
   input  logic       sb_ack
);

   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

   logic [7:0] cnt;

   // cnt = strobe cycles already spent without ack
   assign ack_done = sb_stb & sb_ack;
   assign timeout  = sb_stb & ~sb_ack & (cnt == TO_LAST);

`ifdef SPI_CFG_VERIFY_EN
   assign rdata = sb_dat_r;
`else
   logic unused_dat_r;
   assign unused_dat_r = ^sb_dat_r;
   assign rdata = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_adr   <= 8'h00;
         sb_dat_w <= 8'h00;
         sb_we    <= 1'b0;
         sb_stb   <= 1'b0;
         cnt      <= 8'h00;
      end else if (req) begin
         sb_adr   <= adr;
         sb_dat_w <= dat;
         sb_we    <= we;
         sb_stb   <= 1'b1;
         cnt      <= 8'h00;
      end else if (ack_done || timeout) begin
         sb_stb <= 1'b0;
         sb_we  <= 1'b0;
      end else if (sb_stb) begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_ip_cfg_seq.sv
// Config sequencer: ROM (addr,value) pairs -> SB_SPI bus writes.
// Ports: start, rom_addr/rom_data, sb_* bus, busy/done/err status.
// SPI_CFG_VERIFY_EN: read back each register and flag mismatches.
module spi_ip_cfg_seq
   import spi_ip_pkg::*;
#(
   parameter int unsigned ROM_AW      = 4,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [7:0]        sb_adr,
   output logic [7:0]        sb_dat_w,
   input  logic [7:0]        sb_dat_r,
   output logic              sb_we,
   output logic              sb_stb,
   input  logic              sb_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t     state;
   logic       marker;
   logic       last;
   logic       req;
   logic       we;
   logic [7:0] adr;
   logic [7:0] dat;
   logic       ack_done;
   logic       timeout;
   logic [7:0] rdata;

   // rom_addr is the entry index itself
   assign marker = (rom_data[15:8] == END_MARKER);
   assign last   = &rom_addr;

`ifdef SPI_CFG_VERIFY_EN
   logic rd_go;
`else
   logic unused_rd;
   assign unused_rd = ^rdata;
`endif

   always_comb begin
      req = 1'b0;
      we  = 1'b1;
      adr = rom_data[15:8];
      dat = rom_data[7:0];
      if (state == ST_DECODE && !marker)
         req = 1'b1;
`ifdef SPI_CFG_VERIFY_EN
      if (state == ST_READ && rd_go) begin
         req = 1'b1;
         we  = 1'b0;
         adr = sb_adr;
         dat = sb_dat_w;
      end
`endif
   end

   sb_bus_master #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_bus (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .adr      (adr),
      .dat      (dat),
      .ack_done (ack_done),
      .timeout  (timeout),
      .rdata    (rdata),
      .sb_adr   (sb_adr),
      .sb_dat_w (sb_dat_w),
      .sb_we    (sb_we),
      .sb_stb   (sb_stb),
      .sb_dat_r (sb_dat_r),
      .sb_ack   (sb_ack)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         rom_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef SPI_CFG_VERIFY_EN
         rd_go    <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  rom_addr <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               if (marker) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (timeout) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (ack_done) begin
`ifdef SPI_CFG_VERIFY_EN
                  rd_go <= 1'b1;
                  state <= ST_READ;
`else
                  // last slot written without a marker
                  if (last) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= ST_FETCH;
                  end
`endif
               end
            end
`ifdef SPI_CFG_VERIFY_EN
            ST_READ: begin
               // one idle bus cycle between write and read strobes
               if (rd_go) begin
                  rd_go <= 1'b0;
               end else if (timeout) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (ack_done) begin
                  if (rdata != sb_dat_w)
                     err <= 1'b1;
                  if (last) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= ST_FETCH;
                  end
               end
            end
`endif
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ip_cfg_seq.sv
// Directed bench for spi_ip_cfg_seq with ROM and SB_SPI slave models.
// Optional SPI_CFG_VERIFY_EN section exercises read-back mismatch.
module tb_spi_ip_cfg_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  sb_adr;
   logic [7:0]  sb_dat_w;
   logic [7:0]  sb_dat_r = 8'h00;
   logic        sb_we;
   logic        sb_stb;
   logic        sb_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        err;

   int tests = 0;
   int fails = 0;

   logic [15:0] rom [16];
   logic [7:0]  regs [256];
   int          ack_lat = 2;
   bit          poison = 1'b0;

   logic [7:0] wa [$];
   logic [7:0] wd [$];
   logic [7:0] ra [$];
   int nstb, run, last_run, gap, min_gap, busy_cyc, scnt;
   bit left0, wrap0, prev_stb;

   logic [7:0] exp_a [5] = '{8'h07, 8'h0F, 8'h09, 8'h0A, 8'h0B};
   logic [7:0] exp_d [5] = '{8'h00, 8'h01, 8'h80, 8'h00, 8'h0B};

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   spi_ip_cfg_seq #(
      .ROM_AW(4),
      .ACK_TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .sb_adr   (sb_adr),
      .sb_dat_w (sb_dat_w),
      .sb_dat_r (sb_dat_r),
      .sb_we    (sb_we),
      .sb_stb   (sb_stb),
      .sb_ack   (sb_ack),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave: acks on strobe cycle ack_lat (0 = never), logs traffic
   always @(negedge clk) begin
      if (sb_stb) begin
         if (!prev_stb) begin
            if (nstb > 0 && gap < min_gap) min_gap = gap;
            nstb++;
         end
         gap = 0;
         run++;
         sb_ack = (ack_lat != 0) && (scnt == ack_lat - 1);
         scnt++;
         sb_dat_r = (poison && sb_adr == 8'h09) ? 8'h00 : regs[sb_adr];
         if (sb_ack) begin
            if (sb_we) begin
               wa.push_back(sb_adr);
               wd.push_back(sb_dat_w);
               regs[sb_adr] = sb_dat_w;
            end else begin
               ra.push_back(sb_adr);
            end
         end
      end else begin
         sb_ack = 1'b0;
         scnt = 0;
         if (prev_stb) last_run = run;
         run = 0;
         gap++;
      end
      prev_stb = sb_stb;
      if (busy) begin
         busy_cyc++;
         if (rom_addr != 4'd0) left0 = 1'b1;
         else if (left0) wrap0 = 1'b1;
      end
   end

   task automatic clr();
      wa.delete();
      wd.delete();
      ra.delete();
      nstb = 0;
      min_gap = 999;
      busy_cyc = 0;
      left0 = 1'b0;
      wrap0 = 1'b0;
      last_run = 0;
   endtask

   task automatic std_rom();
      for (int i = 0; i < 16; i++) rom[i] = 16'hFF00;
      for (int i = 0; i < 5; i++) rom[i] = {exp_a[i], exp_d[i]};
   endtask

   task automatic run_seq(input int limit, input int poke, output int lat);
      int k;
      k = 0;
      lat = 0;
      @(posedge clk); #1;
      clr();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && k < limit) begin
         @(negedge clk);
         k++;
         if (sb_stb && lat == 0) lat = k;
         start = (poke != 0 && k == poke);
      end
      start = 1'b0;
      #1;
      if (!done) chk("done_wait", 32'd0, 32'd1);
   endtask

   task automatic chk_std(input string pfx);
      chk({pfx, "_nwr"}, wa.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("%s_adr%0d", pfx, i),
             (i < wa.size()) ? 32'(wa[i]) : 32'hDEAD, 32'(exp_a[i]));
         chk($sformatf("%s_dat%0d", pfx, i),
             (i < wd.size()) ? 32'(wd[i]) : 32'hDEAD, 32'(exp_d[i]));
      end
      chk({pfx, "_done"}, done, 1);
      chk({pfx, "_busy"}, busy, 0);
   endtask

   initial begin
      int lat;
      int k;
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      std_rom();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs",
          {rom_addr, sb_adr, sb_dat_w, sb_we, sb_stb, busy, done, err}, 0);
      rst = 1'b0;

      ack_lat = 2;
      run_seq(200, 0, lat);
      chk_std("std");
      chk("std_err", err, 0);
      chk("std_lat", lat, 3);
`ifndef SPI_CFG_VERIFY_EN
      chk("std_busy_cyc", busy_cyc, 22);
      chk("std_gap", min_gap, 2);
`endif

      ack_lat = 0;
      run_seq(60, 0, lat);
      chk("to_run", last_run, 16);
      chk("to_stb", sb_stb, 0);
      chk("to_err", err, 1);
      chk("to_done", done, 1);
      chk("to_nwr", wa.size(), 0);
      chk("to_nstb", nstb, 1);

      ack_lat = 3;
      @(posedge clk); #1;
      clr();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!(nstb == 2 && sb_stb) && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      chk("mid_reached", nstb == 2 && sb_stb, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_outs",
          {rom_addr, sb_adr, sb_dat_w, sb_we, sb_stb, busy, done, err}, 0);
      rst = 1'b0;
      ack_lat = 2;
      run_seq(200, 0, lat);
      chk_std("rst_again");
      chk("rst_again_err", err, 0);

      for (int i = 0; i < 16; i++) rom[i] = {8'(8'h10 + i), 8'(i * 3)};
      run_seq(200, 0, lat);
      chk("nm_nwr", wa.size(), 16);
      chk("nm_last_adr", (wa.size() == 16) ? 32'(wa[15]) : 32'hDEAD, 32'h1F);
      chk("nm_last_dat", (wd.size() == 16) ? 32'(wd[15]) : 32'hDEAD, 32'h2D);
      chk("nm_err", err, 1);
      chk("nm_done", done, 1);
      chk("nm_wrap0", wrap0, 0);

      std_rom();
      run_seq(200, 7, lat);
      chk_std("poke");
      chk("poke_err", err, 0);
      @(posedge clk); #1;
      chk("poke_idle_busy", busy, 0);

`ifdef SPI_CFG_VERIFY_EN
      poison = 1'b1;
      run_seq(300, 0, lat);
      chk_std("vfy");
      chk("vfy_err", err, 1);
      chk("vfy_nrd", ra.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("vfy_rd%0d", i),
             (i < ra.size()) ? 32'(ra[i]) : 32'hDEAD, 32'(exp_a[i]));
      poison = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
